fdc_sd_arbiter: RTL and testbench

- Shares one MiSTer SD block-level port (one LBA, one rd/wr/ack, one buffer data bus) among NUM_CH floppy drive channels.
- Each channel is one wd1793 instance inside the floppy controller. Each channel keeps its own sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_din handshake.
- Round-robin arbitration: one block transfer per grant, with an ack watchdog.
- Sits between the floppy controller and the hps_io SD interface, so the top level exposes a single SD slot.

---
 rtl/fdc_pkg.sv | 18 +
 rtl/fdc_sd_arbiter_if.sv | 37 +++
 rtl/rr_pick.sv | 32 +++
 rtl/fdc_sd_arbiter.sv | 144 ++++++++++++++
 tb/tb_fdc_sd_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdc_pkg.sv
// Shared types for the floppy-controller SD port arbiter.
package fdc_pkg;

    // Arbiter phases: wait for a requester, hold the host request, follow the
    // host ack, then one settle cycle that advances the round-robin pointer.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } sd_arb_state_t;

    localparam int unsigned MAX_DRIVES = 8;

    // Channel index; fixed at 3 bits so at most MAX_DRIVES channels.
    typedef logic [2:0] drv_idx_t;

endpackage

// File: rtl/fdc_sd_arbiter_if.sv
// Bundle of per-channel SD handshakes plus the single host-side SD slot.
interface fdc_sd_arbiter_if #(
    parameter int unsigned NUM_CH = 4
);
    // Drive-channel side
    logic [31:0]       ch_lba      [NUM_CH];
    logic [NUM_CH-1:0] ch_rd;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] ch_ack;
    logic [7:0]        ch_buff_din [NUM_CH];
    logic [NUM_CH-1:0] ch_buff_wr;

    // Host (hps_io) side
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;

    // Status
    logic              busy;
    fdc_pkg::drv_idx_t grant;
    logic              tmo_err;

    // Arbiter view
    modport master (
        input  ch_lba, ch_rd, ch_wr, ch_buff_din, sd_ack, sd_buff_wr,
        output ch_ack, ch_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant, tmo_err
    );

    // Channels and host view
    modport slave (
        output ch_lba, ch_rd, ch_wr, ch_buff_din, sd_ack, sd_buff_wr,
        input  ch_ack, ch_buff_wr, sd_lba, sd_rd, sd_wr, sd_buff_din, busy, grant, tmo_err
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after i_rr_ptr, wrapping.
module rr_pick
    import fdc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] i_req,
    input  drv_idx_t          i_rr_ptr,
    output logic              o_found,
    output drv_idx_t          o_idx
);

    int w_dist;
    int w_best;

    // Smallest circular distance from the slot after i_rr_ptr wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_best  = int'(NUM_CH);
        w_dist  = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_dist = (i + int'(NUM_CH) - 1 - int'(i_rr_ptr)) % int'(NUM_CH);
            if (i_req[i] && (w_dist < w_best)) begin
                o_found = 1'b1;
                w_best  = w_dist;
                o_idx   = drv_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Shares one host SD block port among NUM_CH drive channels, one block per grant.
module fdc_sd_arbiter
    import fdc_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TMO_W  = 24
) (
    input  logic             CLK,
    input  logic             RESET_N,
    fdc_sd_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    sd_arb_state_t      r_state, w_state_nxt;
    drv_idx_t           r_rr_ptr, w_rr_ptr_nxt;
    drv_idx_t           r_grant, w_grant_nxt;
    logic [31:0]        r_lba, w_lba_nxt;
    logic               r_sd_rd, w_sd_rd_nxt;
    logic               r_sd_wr, w_sd_wr_nxt;
    logic [TMO_W-1:0]   r_wdog, w_wdog_nxt, w_wdog_inc;
    logic               r_tmo_err, w_tmo_err_nxt;

    logic [NUM_CH-1:0]  w_req;
    logic               w_found;
    drv_idx_t           w_pick;
    logic [IDX_W-1:0]   w_psel;
    logic [IDX_W-1:0]   w_gsel;
    logic               w_route;

    // A channel asking for both read and write is treated as a read.
    assign w_req      = bus.ch_rd | bus.ch_wr;
    assign w_psel     = w_pick[IDX_W-1:0];
    assign w_gsel     = r_grant[IDX_W-1:0];
    assign w_wdog_inc = r_wdog + TMO_W'(1);
    assign w_route    = (r_state == ISSUE) || (r_state == XFER);

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_found  (w_found),
        .o_idx    (w_pick)
    );

    // State and latched transfer context.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_rr_ptr  <= drv_idx_t'(NUM_CH - 1);
            r_grant   <= '0;
            r_lba     <= '0;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_wdog    <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_lba     <= w_lba_nxt;
            r_sd_rd   <= w_sd_rd_nxt;
            r_sd_wr   <= w_sd_wr_nxt;
            r_wdog    <= w_wdog_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    // Next-state: grant, hold request until ack/withdraw/timeout, follow ack, settle.
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_lba_nxt     = r_lba;
        w_sd_rd_nxt   = r_sd_rd;
        w_sd_wr_nxt   = r_sd_wr;
        w_wdog_nxt    = r_wdog;
        w_tmo_err_nxt = r_tmo_err;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = ISSUE;
                    w_grant_nxt = w_pick;
                    w_lba_nxt   = bus.ch_lba[w_psel];
                    w_sd_rd_nxt = bus.ch_rd[w_psel];
                    w_sd_wr_nxt = !bus.ch_rd[w_psel];
                end
            end
            ISSUE: begin
                w_wdog_nxt = w_wdog_inc;
                if (bus.sd_ack) begin
                    w_sd_rd_nxt = 1'b0;
                    w_sd_wr_nxt = 1'b0;
                    w_state_nxt = XFER;
                end else if (!w_req[w_gsel]) begin
                    w_sd_rd_nxt = 1'b0;
                    w_sd_wr_nxt = 1'b0;
                    w_state_nxt = DONE;
                end else if (&w_wdog_inc) begin
                    w_sd_rd_nxt   = 1'b0;
                    w_sd_wr_nxt   = 1'b0;
                    w_tmo_err_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            XFER: begin
                if (!bus.sd_ack) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_rr_ptr_nxt = r_grant;
                w_wdog_nxt   = '0;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Route host ack, buffer strobe and write data to the granted channel only.
    always_comb begin
        bus.ch_ack      = '0;
        bus.ch_buff_wr  = '0;
        bus.sd_buff_din = 8'h00;
        if (w_route) begin
            bus.sd_buff_din = bus.ch_buff_din[w_gsel];
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (r_grant == drv_idx_t'(i)) begin
                    bus.ch_ack[i]     = bus.sd_ack;
                    bus.ch_buff_wr[i] = bus.sd_buff_wr & bus.sd_ack;
                end
            end
        end
    end

    assign bus.sd_lba  = r_lba;
    assign bus.sd_rd   = r_sd_rd;
    assign bus.sd_wr   = r_sd_wr;
    assign bus.busy    = (r_state != IDLE);
    assign bus.grant   = r_grant;
    assign bus.tmo_err = r_tmo_err;

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Bench for fdc_sd_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_fdc_sd_arbiter;
    import fdc_pkg::*;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned TMO_W     = 4;
    localparam int          TMO_LIMIT = 15;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    fdc_sd_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    fdc_sd_arbiter #(
        .NUM_CH (NUM_CH),
        .TMO_W  (TMO_W)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Transaction model ----------------
    // m_busy: a channel owns the port; m_req: host request outstanding;
    // m_acked: host has acknowledged; m_close: one settle cycle pending.
    logic        m_busy, m_req, m_acked, m_close, m_rd_op, m_tmo;
    logic [1:0]  m_g, m_ptr;
    logic [31:0] m_lba;
    int          m_wait;

    function automatic logic has_req(input logic [3:0] req);
        return |req;
    endfunction

    function automatic logic [1:0] first_after(input logic [1:0] ptr, input logic [3:0] req);
        logic [1:0] c;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            c = 2'((int'(ptr) + k) % int'(NUM_CH));
            if (req[c]) return c;
        end
        return 2'd0;
    endfunction

    function automatic logic [31:0] onehot(input logic [1:0] g);
        logic [3:0] v;
        v = 4'b0001 << g;
        return 32'(v);
    endfunction

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_busy  <= 1'b0;
            m_req   <= 1'b0;
            m_acked <= 1'b0;
            m_close <= 1'b0;
            m_rd_op <= 1'b0;
            m_tmo   <= 1'b0;
            m_g     <= 2'd0;
            m_ptr   <= 2'(NUM_CH - 1);
            m_lba   <= 32'd0;
            m_wait  <= 0;
        end else if (!m_busy) begin
            if (has_req(bus.ch_rd | bus.ch_wr)) begin
                m_busy  <= 1'b1;
                m_req   <= 1'b1;
                m_g     <= first_after(m_ptr, bus.ch_rd | bus.ch_wr);
                m_lba   <= bus.ch_lba[first_after(m_ptr, bus.ch_rd | bus.ch_wr)];
                m_rd_op <= bus.ch_rd[first_after(m_ptr, bus.ch_rd | bus.ch_wr)];
                m_wait  <= 0;
            end
        end else if (m_close) begin
            m_busy  <= 1'b0;
            m_close <= 1'b0;
            m_ptr   <= m_g;
        end else if (m_req) begin
            m_wait <= m_wait + 1;
            if (bus.sd_ack) begin
                m_req   <= 1'b0;
                m_acked <= 1'b1;
            end else if (!(bus.ch_rd[m_g] || bus.ch_wr[m_g])) begin
                m_req   <= 1'b0;
                m_close <= 1'b1;
            end else if (m_wait + 1 == TMO_LIMIT) begin
                m_req   <= 1'b0;
                m_tmo   <= 1'b1;
                m_close <= 1'b1;
            end
        end else if (m_acked) begin
            if (!bus.sd_ack) begin
                m_acked <= 1'b0;
                m_close <= 1'b1;
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    always @(negedge CLK) begin
        if (RESET_N) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("sd_rd", 32'(bus.sd_rd), 32'(m_req && m_rd_op));
            check("sd_wr", 32'(bus.sd_wr), 32'(m_req && !m_rd_op));
            check("sd_lba", bus.sd_lba, m_lba);
            check("grant", 32'(bus.grant), 32'(m_g));
            check("tmo_err", 32'(bus.tmo_err), 32'(m_tmo));
            check("ch_ack", 32'(bus.ch_ack),
                  ((m_req || m_acked) && bus.sd_ack) ? onehot(m_g) : 32'd0);
            check("ch_buff_wr", 32'(bus.ch_buff_wr),
                  ((m_req || m_acked) && bus.sd_ack && bus.sd_buff_wr) ? onehot(m_g) : 32'd0);
            check("sd_buff_din", 32'(bus.sd_buff_din),
                  (m_req || m_acked) ? 32'(bus.ch_buff_din[m_g]) : 32'd0);
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.sd_rd || bus.sd_wr) && n < 40);
        check(name, 32'(bus.sd_rd || bus.sd_wr), 32'd1);
    endtask

    // Host acks after 3 request cycles, then release; checks DONE and return to idle.
    task automatic serve_tail();
        step();
        step();
        bus.sd_ack = 1'b1;
        step();
        bus.sd_ack = 1'b0;
        step();
        check("done sd_rd", 32'(bus.sd_rd), 32'd0);
        check("done busy", 32'(bus.busy), 32'd1);
        step();
        check("idle busy", 32'(bus.busy), 32'd0);
    endtask

    int grant_exp [5] = '{0, 1, 2, 3, 0};
    int n_hi;

    initial begin
        bus.ch_rd      = '0;
        bus.ch_wr      = '0;
        bus.sd_ack     = 1'b0;
        bus.sd_buff_wr = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            bus.ch_lba[i]      = 32'h100 + 32'(i);
            bus.ch_buff_din[i] = 8'h50 + 8'(i);
        end

        // Reset state
        step();
        step();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst sd_rd", 32'(bus.sd_rd), 32'd0);
        check("rst grant", 32'(bus.grant), 32'd0);
        check("rst sd_lba", bus.sd_lba, 32'd0);
        check("rst tmo_err", 32'(bus.tmo_err), 32'd0);
        check("rst ch_ack", 32'(bus.ch_ack), 32'd0);
        RESET_N = 1'b1;

        // Round-robin with all channels requesting
        bus.ch_rd = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_req("rr req");
            check("rr grant", 32'(bus.grant), 32'(grant_exp[t]));
            serve_tail();
        end
        bus.ch_rd = 4'b0000;
        step();

        // Single read on channel 2
        bus.ch_lba[2] = 32'h12;
        bus.ch_rd     = 4'b0100;
        step();
        check("rd sd_rd", 32'(bus.sd_rd), 32'd1);
        check("rd sd_lba", bus.sd_lba, 32'h12);
        check("rd grant", 32'(bus.grant), 32'd2);
        bus.sd_ack = 1'b1;
        #1;
        check("rd ch_ack", 32'(bus.ch_ack), 32'b0100);
        step();
        check("rd sd_rd drop", 32'(bus.sd_rd), 32'd0);
        check("rd ch_ack xfer", 32'(bus.ch_ack), 32'b0100);
        bus.ch_rd  = 4'b0000;
        bus.sd_ack = 1'b0;
        step();
        step();
        check("rd idle", 32'(bus.busy), 32'd0);

        // Write path on channel 1
        bus.ch_buff_din[1] = 8'hA5;
        bus.ch_buff_din[0] = 8'h3C;
        bus.ch_wr          = 4'b0010;
        step();
        check("wr sd_wr", 32'(bus.sd_wr), 32'd1);
        check("wr sd_rd", 32'(bus.sd_rd), 32'd0);
        check("wr grant", 32'(bus.grant), 32'd1);
        check("wr din", 32'(bus.sd_buff_din), 32'hA5);
        bus.sd_ack     = 1'b1;
        bus.sd_buff_wr = 1'b1;
        #1;
        check("wr bwr", 32'(bus.ch_buff_wr), 32'b0010);
        step();
        bus.sd_buff_wr = 1'b0;
        #1;
        check("wr bwr gap", 32'(bus.ch_buff_wr), 32'd0);
        bus.sd_buff_wr = 1'b1;
        #1;
        check("wr bwr 2", 32'(bus.ch_buff_wr), 32'b0010);
        step();
        bus.ch_wr  = 4'b0000;
        bus.sd_ack = 1'b0;
        #1;
        check("wr bwr no ack", 32'(bus.ch_buff_wr), 32'd0);
        step();
        check("done bwr", 32'(bus.ch_buff_wr), 32'd0);
        check("done din", 32'(bus.sd_buff_din), 32'd0);
        bus.sd_buff_wr = 1'b0;
        bus.sd_ack     = 1'b1;
        #1;
        check("done ack glitch", 32'(bus.ch_ack), 32'd0);
        step();
        bus.sd_ack = 1'b0;
        check("wr idle", 32'(bus.busy), 32'd0);

        // Host ack while idle is ignored
        bus.sd_ack = 1'b1;
        step();
        step();
        check("idle ack busy", 32'(bus.busy), 32'd0);
        check("idle ack ch_ack", 32'(bus.ch_ack), 32'd0);
        bus.sd_ack = 1'b0;

        // Withdraw on channel 3
        bus.ch_lba[3] = 32'h77;
        bus.ch_rd     = 4'b1000;
        wait_req("wd req");
        check("wd grant", 32'(bus.grant), 32'd3);
        check("wd lba", bus.sd_lba, 32'h77);
        repeat (4) step();
        check("wd held", 32'(bus.sd_rd), 32'd1);
        bus.ch_rd = 4'b0000;
        step();
        check("wd sd_rd", 32'(bus.sd_rd), 32'd0);
        check("wd ch_ack", 32'(bus.ch_ack), 32'd0);
        check("wd busy1", 32'(bus.busy), 32'd1);
        step();
        check("wd busy2", 32'(bus.busy), 32'd0);

        // Watchdog: channel 0 never acked, channel 1 served next
        bus.ch_rd = 4'b0011;
        wait_req("tmo req");
        check("tmo grant", 32'(bus.grant), 32'd0);
        n_hi = 0;
        while (bus.sd_rd && n_hi < 40) begin
            n_hi++;
            step();
        end
        check("tmo cycles", 32'(n_hi), 32'd15);
        check("tmo flag", 32'(bus.tmo_err), 32'd1);
        wait_req("tmo next req");
        check("tmo next grant", 32'(bus.grant), 32'd1);
        serve_tail();
        check("tmo sticky", 32'(bus.tmo_err), 32'd1);
        bus.ch_rd = 4'b0000;
        step();

        // Asynchronous reset mid-transfer
        bus.ch_rd = 4'b0100;
        wait_req("ar req");
        bus.sd_ack = 1'b1;
        step();
        check("ar xfer ack", 32'(bus.ch_ack), 32'b0100);
        RESET_N = 1'b0;
        #1;
        check("ar sd_rd", 32'(bus.sd_rd), 32'd0);
        check("ar ch_ack", 32'(bus.ch_ack), 32'd0);
        check("ar busy", 32'(bus.busy), 32'd0);
        check("ar tmo", 32'(bus.tmo_err), 32'd0);
        check("ar grant", 32'(bus.grant), 32'd0);
        check("ar lba", bus.sd_lba, 32'd0);
        bus.sd_ack = 1'b0;
        bus.ch_rd  = 4'b0000;
        step();
        step();
        RESET_N   = 1'b1;
        bus.ch_rd = 4'b1111;
        wait_req("ar first req");
        check("ar first grant", 32'(bus.grant), 32'd0);
        serve_tail();
        bus.ch_rd = 4'b0000;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
